// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU request arbiter / sequencer.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } state_e;

  // Unit select, taken from alu_fun[3:2]
  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  localparam int DEFAULT_TIMEOUT = 8;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-requester grant logic. ALU_ARB_RR_EN selects round-robin; otherwise
// requester 0 has fixed priority and no pointer state exists.
module alu_rr_arbiter (
`ifdef ALU_ARB_RR_EN
  input  logic       clk_i,
  input  logic       rst_ni,
`endif
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  // On contention the requester not granted last wins
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (accept_i) last_d = gnt_o[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  logic unused_accept;
  assign unused_accept = accept_i;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = 2'b01;
  end
`endif

endmodule

// File: rtl/alu_arb_ctrl.sv
// Arbitrates two requesters onto an external ALU and returns one response
// per operation. Optional round-robin arbitration via ALU_ARB_RR_EN.
module alu_arb_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_LINE   = 4,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [SEL_LINE-1:0]   req0_fun,
  input  logic [SEL_LINE-1:0]   req1_fun,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [SEL_LINE-1:0]   alu_fun,
  input  logic [DATA_WIDTH-1:0] arith_out,
  input  logic [DATA_WIDTH-1:0] logic_out,
  input  logic [DATA_WIDTH-1:0] cmp_out,
  input  logic [DATA_WIDTH-1:0] shift_out,
  input  logic                  carry_out,
  input  logic                  arith_flag,
  input  logic                  logic_flag,
  input  logic                  cmp_flag,
  input  logic                  shift_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_carry,
  output logic                  rsp_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_b_q, rsp_data_q;
  logic [SEL_LINE-1:0]     alu_fun_q;
  logic                    rsp_valid_q, rsp_id_q, rsp_carry_q, rsp_err_q;
  logic [1:0]              gnt;
  logic                    accept, sel_flag, sel_carry;
  logic [DATA_WIDTH-1:0]   sel_data;

  alu_rr_arbiter u_arb (
`ifdef ALU_ARB_RR_EN
    .clk_i    (clk),
    .rst_ni   (async_rst),
`endif
    .req_i    ({req1_valid, req0_valid}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  // Gated by reset so ready stays low while reset is held
  assign req0_ready = async_rst && (state_q == IDLE) && gnt[0];
  assign req1_ready = async_rst && (state_q == IDLE) && gnt[1];
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    sel_flag  = 1'b0;
    sel_data  = '0;
    sel_carry = 1'b0;
    case (alu_fun_q[3:2])
      ARITH: begin sel_flag = arith_flag; sel_data = arith_out; sel_carry = carry_out; end
      LOGIC: begin sel_flag = logic_flag; sel_data = logic_out; end
      CMP:   begin sel_flag = cmp_flag;   sel_data = cmp_out;   end
      SHIFT: begin sel_flag = shift_flag; sel_data = shift_out; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          alu_a_q   <= gnt[1] ? req1_a   : req0_a;
          alu_b_q   <= gnt[1] ? req1_b   : req0_b;
          alu_fun_q <= gnt[1] ? req1_fun : req0_fun;
          rsp_id_q  <= gnt[1];
          state_q   <= EXEC;
        end
        EXEC: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (sel_flag) begin
            rsp_data_q  <= sel_data;
            rsp_carry_q <= sel_carry;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Self-checking bench for alu_arb_ctrl: directed vector table, reset corner
// cases and randomized operations against a transaction-level model.
module tb_alu_arb_ctrl;

  localparam int DW = 16;
  localparam int SL = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic async_rst = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [SL-1:0] req0_fun = '0, req1_fun = '0;
  logic [DW-1:0] alu_a, alu_b;
  logic [SL-1:0] alu_fun;
  logic [DW-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic carry_out = 1'b0, arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_carry, rsp_err;
  logic [DW-1:0] rsp_data;

  int checks = 0;
  int errors = 0;
  logic mdl_last = 1'b1;

  always #5 clk = ~clk;

  alu_arb_ctrl #(.DATA_WIDTH(DW), .SEL_LINE(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .async_rst(async_rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_fun(req0_fun), .req1_fun(req1_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .carry_out(carry_out), .arith_flag(arith_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  typedef struct {
    logic          v0, v1;
    logic [DW-1:0] a0, b0, a1, b1;
    logic [SL-1:0] f0, f1;
    logic [DW-1:0] res;
    logic          carry;
    int            d;      // WAIT cycles before the selected flag rises
    int            r;      // RESP cycles with rsp_ready low
    logic          exp_id;
    logic [DW-1:0] exp_data;
    logic          exp_carry, exp_err;
  } vec_t;

  function automatic vec_t mk(input logic v0, v1, input logic [DW-1:0] a0, b0,
                              input logic [SL-1:0] f0, input logic [DW-1:0] a1, b1,
                              input logic [SL-1:0] f1, input logic [DW-1:0] res,
                              input logic carry, input int d, r, input logic eid,
                              input logic [DW-1:0] edata, input logic ec, ee);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.f0 = f0;
    v.a1 = a1; v.b1 = b1; v.f1 = f1; v.res = res; v.carry = carry;
    v.d = d; v.r = r; v.exp_id = eid; v.exp_data = edata;
    v.exp_carry = ec; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plays the external ALU: selected unit gets res/flag, others get noise.
  task automatic drive(input logic [1:0] u, input logic [DW-1:0] res, input logic c,
                       input logic fl, input logic scramble);
    logic [DW-1:0] rv;
    rv = scramble ? DW'($urandom) : res;
    arith_out  = (u == 2'd0) ? rv : DW'($urandom);
    logic_out  = (u == 2'd1) ? rv : DW'($urandom);
    cmp_out    = (u == 2'd2) ? rv : DW'($urandom);
    shift_out  = (u == 2'd3) ? rv : DW'($urandom);
    carry_out  = scramble ? 1'($urandom) : c;
    arith_flag = (u == 2'd0) ? fl : 1'($urandom);
    logic_flag = (u == 2'd1) ? fl : 1'($urandom);
    cmp_flag   = (u == 2'd2) ? fl : 1'($urandom);
    shift_flag = (u == 2'd3) ? fl : 1'($urandom);
  endtask

  // Starts just after a rising edge with the DUT idle; ends the same way.
  task automatic run_op(input vec_t v);
    logic [SL-1:0] f;
    logic [DW-1:0] ea, eb;
    int ec;
    f  = v.exp_id ? v.f1 : v.f0;
    ea = v.exp_id ? v.a1 : v.a0;
    eb = v.exp_id ? v.b1 : v.b0;
    ec = (v.d < TO) ? 3 + v.d : 2 + TO;
    req0_valid = v.v0; req1_valid = v.v1;
    req0_a = v.a0; req0_b = v.b0; req0_fun = v.f0;
    req1_a = v.a1; req1_b = v.b1; req1_fun = v.f1;
    rsp_ready = 1'b0;
    drive(f[3:2], v.res, v.carry, 1'b0, 1'b0);
    @(negedge clk);
    chk("grant_ready0", req0_ready, !v.exp_id);
    chk("grant_ready1", req1_ready, v.exp_id);
    for (int cyc = 1; cyc <= ec + v.r; cyc++) begin
      @(posedge clk); #1;
      drive(f[3:2], v.res, v.carry, (cyc >= 2) && (cyc - 2 >= v.d), cyc >= ec);
      rsp_ready = (cyc >= ec + v.r);
      @(negedge clk);
      chk("busy_ready0", req0_ready, 0);
      chk("busy_ready1", req1_ready, 0);
      if (cyc == 1) begin
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_fun", alu_fun, f);
      end
      chk("rsp_valid", rsp_valid, cyc >= ec);
      if (cyc >= ec) begin
        chk("rsp_id", rsp_id, v.exp_id);
        chk("rsp_data", rsp_data, v.exp_data);
        chk("rsp_carry", rsp_carry, v.exp_carry);
        chk("rsp_err", rsp_err, v.exp_err);
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    drive(f[3:2], v.res, v.carry, 1'b0, 1'b1);
    @(negedge clk);
    chk("after_hs_valid", rsp_valid, 0);
    chk("after_hs_alu_a_hold", alu_a, ea);
    @(posedge clk); #1;
    mdl_last = v.exp_id;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_fun"}, alu_fun, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_carry"}, rsp_carry, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  vec_t tbl[10];
  vec_t v;
  logic [SL-1:0] fs;

  initial begin
    // Contention pairs: round-robin alternates from requester 0, fixed stays on 0
`ifdef ALU_ARB_RR_EN
    tbl[0] = mk(1,1, 16'd1,16'd2,4'b0000, 16'd10,16'd20,4'b0100, 16'h0042,0, 0,0, 0,16'h0042,0,0);
    tbl[1] = mk(1,1, 16'd1,16'd2,4'b0000, 16'd10,16'd20,4'b0100, 16'h0042,0, 0,0, 1,16'h0042,0,0);
    tbl[2] = mk(1,1, 16'd1,16'd2,4'b0000, 16'd10,16'd20,4'b0100, 16'h0042,0, 0,0, 0,16'h0042,0,0);
    tbl[3] = mk(1,1, 16'd1,16'd2,4'b0000, 16'd10,16'd20,4'b0100, 16'h0042,0, 0,0, 1,16'h0042,0,0);
`else
    tbl[0] = mk(1,1, 16'd1,16'd2,4'b0000, 16'd10,16'd20,4'b0100, 16'h0042,0, 0,0, 0,16'h0042,0,0);
    tbl[1] = mk(1,1, 16'd1,16'd2,4'b0000, 16'd10,16'd20,4'b0100, 16'h0042,0, 0,0, 0,16'h0042,0,0);
    tbl[2] = mk(1,1, 16'd1,16'd2,4'b0000, 16'd10,16'd20,4'b0100, 16'h0042,0, 0,0, 0,16'h0042,0,0);
    tbl[3] = mk(1,1, 16'd1,16'd2,4'b0000, 16'd10,16'd20,4'b0100, 16'h0042,0, 0,0, 0,16'h0042,0,0);
`endif
    tbl[4] = mk(1,0, 16'd5,16'd3,4'b0000, 16'd0,16'd0,4'b0000, 16'd8,0, 0,0, 0,16'd8,0,0);
    tbl[5] = mk(0,1, 16'd0,16'd0,4'b0000, 16'hF0F0,16'h0FF0,4'b0100, 16'h00F0,1, 1,1, 1,16'h00F0,0,0);
    tbl[6] = mk(1,0, 16'd7,16'd9,4'b1000, 16'd0,16'd0,4'b0000, 16'h1234,0, TO+2,0, 0,16'h0000,0,1);
    tbl[7] = mk(0,1, 16'd0,16'd0,4'b0000, 16'h0003,16'h0001,4'b1100, 16'hBEEF,1, 2,5, 1,16'hBEEF,0,0);
    tbl[8] = mk(1,0, 16'hFFFF,16'h0001,4'b0001, 16'd0,16'd0,4'b0000, 16'hFFFF,1, TO-1,0, 0,16'hFFFF,1,0);
    tbl[9] = mk(0,1, 16'd0,16'd0,4'b0000, 16'h0002,16'h0002,4'b0010, 16'h5555,1, TO,2, 1,16'h0000,0,1);

    // Reset held with both requesters valid
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    async_rst = 1'b1;
    mdl_last = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i]);

    // Reset during WAIT aborts the operation
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_fun = 4'b0000;
    drive(2'd0, 16'h3333, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #2 async_rst = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    async_rst = 1'b1;
    mdl_last = 1'b1;
    @(negedge clk);
    chk("midrst_no_stale", rsp_valid, 0);
    @(posedge clk); #1;
    run_op(mk(0,1, 16'd0,16'd0,4'b0000, 16'h00AA,16'h0055,4'b0111, 16'h00FF,1, 0,1, 1,16'h00FF,0,0));

    // Randomized operations against the transaction model
    for (int n = 0; n < 40; n++) begin
      v.v0 = 1'($urandom); v.v1 = 1'($urandom);
      if (!v.v0 && !v.v1) v.v0 = 1'b1;
      v.a0 = DW'($urandom); v.b0 = DW'($urandom); v.f0 = SL'($urandom);
      v.a1 = DW'($urandom); v.b1 = DW'($urandom); v.f1 = SL'($urandom);
      v.res = DW'($urandom); v.carry = 1'($urandom);
      v.d = $urandom_range(0, TO + 1);
      v.r = $urandom_range(0, 3);
      if (v.v0 && v.v1) begin
`ifdef ALU_ARB_RR_EN
        v.exp_id = ~mdl_last;
`else
        v.exp_id = 1'b0;
`endif
      end else begin
        v.exp_id = v.v1;
      end
      fs = v.exp_id ? v.f1 : v.f0;
      v.exp_err   = (v.d >= TO);
      v.exp_data  = v.exp_err ? '0 : v.res;
      v.exp_carry = (!v.exp_err && fs[3:2] == 2'd0) ? v.carry : 1'b0;
      run_op(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
